// File: rtl/axi_lite_mem_responder.sv
// AXI-lite-style memory responder: DEPTH x 32-bit RAM with independent read and write FSMs.
// One transaction per channel in flight; all outputs are registered.
module axi_lite_mem_responder #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          READ_LAT  = 0,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_LAST = (READ_LAT > 0) ? 4'(READ_LAT - 1) : 4'd0;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  logic [31:0] mem [DEPTH];

  rd_state_t        rd_state, rd_state_n;
  logic [IDX_W-1:0] rd_idx, rd_idx_n;
  logic             rd_ok, rd_ok_n;
  logic [3:0]       lat_cnt, lat_cnt_n;
  logic             arready_n, rvalid_n;
  logic [31:0]      rdata_n;
  logic [15:0]      rd_count_n;

  wr_state_t        wr_state, wr_state_n;
  logic [IDX_W-1:0] wr_idx, wr_idx_n;
  logic             wr_ok, wr_ok_n;
  logic             awready_n, wready_n, bvalid_n;
  logic [15:0]      wr_count_n;
  logic             mem_we;

  logic [31:0] ar_word, aw_word;
  logic        ar_ok, aw_ok;

  // Word offset from BASE_ADDR; the unsigned subtract wraps below the base, hence the >= test.
  always_comb begin
    ar_word = (ARADDR - BASE_ADDR) >> 2;
    aw_word = (AWADDR - BASE_ADDR) >> 2;
    ar_ok   = (ARADDR >= BASE_ADDR) && (ar_word < 32'(DEPTH));
    aw_ok   = (AWADDR >= BASE_ADDR) && (aw_word < 32'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rd_idx   <= '0;
      rd_ok    <= 1'b0;
      lat_cnt  <= 4'd0;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= 32'd0;
      rd_count <= 16'd0;
    end else begin
      rd_state <= rd_state_n;
      rd_idx   <= rd_idx_n;
      rd_ok    <= rd_ok_n;
      lat_cnt  <= lat_cnt_n;
      ARREADY  <= arready_n;
      RVALID   <= rvalid_n;
      RDATA    <= rdata_n;
      rd_count <= rd_count_n;
    end
  end

  // R_DATA spends its first cycle loading RDATA, so RVALID rises 1+READ_LAT cycles after AR.
  always_comb begin
    rd_state_n = rd_state;
    rd_idx_n   = rd_idx;
    rd_ok_n    = rd_ok;
    lat_cnt_n  = lat_cnt;
    arready_n  = ARREADY;
    rvalid_n   = RVALID;
    rdata_n    = RDATA;
    rd_count_n = rd_count;
    case (rd_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (ARVALID && ARREADY) begin
          rd_idx_n  = ar_word[IDX_W-1:0];
          rd_ok_n   = ar_ok;
          lat_cnt_n = LAT_LAST;
          arready_n = 1'b0;
          if (READ_LAT > 0) rd_state_n = R_WAIT;
          else              rd_state_n = R_DATA;
        end
      end
      R_WAIT: begin
        if (lat_cnt == 4'd0) rd_state_n = R_DATA;
        else                 lat_cnt_n  = lat_cnt - 4'd1;
      end
      R_DATA: begin
        if (!RVALID) begin
          rdata_n  = rd_ok ? mem[rd_idx] : ERR_DATA;
          rvalid_n = 1'b1;
        end else if (RREADY) begin
          rvalid_n   = 1'b0;
          arready_n  = 1'b1;
          rd_count_n = rd_count + 16'd1;
          rd_state_n = R_IDLE;
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_idx   <= '0;
      wr_ok    <= 1'b0;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      wr_count <= 16'd0;
    end else begin
      wr_state <= wr_state_n;
      wr_idx   <= wr_idx_n;
      wr_ok    <= wr_ok_n;
      AWREADY  <= awready_n;
      WREADY   <= wready_n;
      BVALID   <= bvalid_n;
      wr_count <= wr_count_n;
    end
  end

  always_comb begin
    wr_state_n = wr_state;
    wr_idx_n   = wr_idx;
    wr_ok_n    = wr_ok;
    awready_n  = AWREADY;
    wready_n   = WREADY;
    bvalid_n   = BVALID;
    wr_count_n = wr_count;
    mem_we     = 1'b0;
    case (wr_state)
      W_IDLE: begin
        awready_n = 1'b1;
        wready_n  = 1'b0;
        if (AWVALID && AWREADY) begin
          wr_idx_n   = aw_word[IDX_W-1:0];
          wr_ok_n    = aw_ok;
          awready_n  = 1'b0;
          wready_n   = 1'b1;
          wr_state_n = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && WREADY) begin
          mem_we     = wr_ok;
          wready_n   = 1'b0;
          bvalid_n   = 1'b1;
          wr_state_n = W_RESP;
        end
      end
      W_RESP: begin
        if (BVALID && BREADY) begin
          bvalid_n   = 1'b0;
          awready_n  = 1'b1;
          wr_count_n = wr_count + 16'd1;
          wr_state_n = W_IDLE;
        end
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  // Gated by reset so an aborted write never lands; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[wr_idx] <= WDATA;
  end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed self-checking bench for axi_lite_mem_responder; a second instance with
// READ_LAT=3 shares the write channel and has its own read channel.
module tb_axi_lite_mem_responder;

  logic        clk, reset;
  logic        ARVALID, RREADY, AWVALID, WVALID, BREADY;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic        ARREADY, RVALID, AWREADY, WREADY, BVALID;
  logic [31:0] RDATA;
  logic [15:0] rd_count, wr_count;

  logic        l_ARVALID, l_RREADY;
  logic [31:0] l_ARADDR;
  logic        l_ARREADY, l_RVALID, l_AWREADY, l_WREADY, l_BVALID;
  logic [31:0] l_RDATA;
  logic [15:0] l_rd_count, l_wr_count;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] d;
  logic [31:0] held;

  axi_lite_mem_responder #(.DEPTH(32), .BASE_ADDR(32'h0), .READ_LAT(0), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  axi_lite_mem_responder #(.DEPTH(32), .BASE_ADDR(32'h0), .READ_LAT(3), .ERR_DATA(32'hDEAD_BEEF)) dut_lat (
    .clk(clk), .reset(reset),
    .ARVALID(l_ARVALID), .ARREADY(l_ARREADY), .ARADDR(l_ARADDR),
    .RVALID(l_RVALID), .RREADY(l_RREADY), .RDATA(l_RDATA),
    .AWVALID(AWVALID), .AWREADY(l_AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(l_WREADY), .WDATA(WDATA),
    .BVALID(l_BVALID), .BREADY(BREADY),
    .rd_count(l_rd_count), .wr_count(l_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Channel drivers: called at a negedge, return at the negedge after the handshake edge.
  task automatic aw_send(input logic [31:0] addr);
    int n = 0;
    AWVALID = 1'b1; AWADDR = addr;
    while (AWREADY !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (AWREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL aw_timeout: AWREADY=%b, required 1", AWREADY); end
    @(negedge clk);
    AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data);
    int n = 0;
    WVALID = 1'b1; WDATA = data;
    while (WREADY !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (WREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL w_timeout: WREADY=%b, required 1", WREADY); end
    @(negedge clk);
    WVALID = 1'b0;
  endtask

  task automatic b_take();
    int n = 0;
    BREADY = 1'b1;
    while (BVALID !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (BVALID !== 1'b1) begin n_fail++; $display("[TB] FAIL b_timeout: BVALID=%b, required 1", BVALID); end
    @(negedge clk);
  endtask

  task automatic ar_send(input logic [31:0] addr);
    int n = 0;
    ARVALID = 1'b1; ARADDR = addr;
    while (ARREADY !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (ARREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_timeout: ARREADY=%b, required 1", ARREADY); end
    @(negedge clk);
    ARVALID = 1'b0;
  endtask

  task automatic r_take(output logic [31:0] data);
    int n = 0;
    RREADY = 1'b1;
    while (RVALID !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++;
    if (RVALID !== 1'b1) begin n_fail++; $display("[TB] FAIL r_timeout: RVALID=%b, required 1", RVALID); end
    data = RDATA;
    @(negedge clk);
    RREADY = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    aw_send(addr);
    w_send(data);
    b_take();
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
    ar_send(addr);
    r_take(data);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ARVALID = 0; ARADDR = 0; RREADY = 0; AWVALID = 0; AWADDR = 0;
    WVALID = 0; WDATA = 0; BREADY = 1;
    l_ARVALID = 0; l_ARADDR = 0; l_RREADY = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ARREADY, AWREADY, RVALID, WREADY, BVALID} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got %b, required 00000", {ARREADY, AWREADY, RVALID, WREADY, BVALID});
    end
    n_cmp++;
    if (RDATA !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h, required 0", RDATA); end
    n_cmp++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      n_fail++; $display("[TB] FAIL reset_counts: rd=%0d wr=%0d, required 0/0", rd_count, wr_count);
    end
    n_cmp++;
    if ({l_ARREADY, l_AWREADY, l_RVALID, l_WREADY, l_BVALID} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_lat_ctrl: got %b, required 00000", {l_ARREADY, l_AWREADY, l_RVALID, l_WREADY, l_BVALID});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ARREADY, AWREADY, l_ARREADY} !== 3'b111) begin
      n_fail++; $display("[TB] FAIL post_reset_ready: got %b, required 111", {ARREADY, AWREADY, l_ARREADY});
    end
  endtask

  task automatic test_write_read();
    aw_send(32'h8);
    n_cmp++;
    if ({AWREADY, WREADY} !== 2'b01) begin n_fail++; $display("[TB] FAIL aw_accept: AWREADY,WREADY=%b, required 01", {AWREADY, WREADY}); end
    w_send(32'hA5A5_0001);
    n_cmp++;
    if (BVALID !== 1'b1) begin n_fail++; $display("[TB] FAIL bvalid_timing: got %b, required 1", BVALID); end
    b_take();
    n_cmp++;
    if (wr_count !== 16'd1 || AWREADY !== 1'b1) begin
      n_fail++; $display("[TB] FAIL after_b: wr_count=%0d AWREADY=%b, required 1/1", wr_count, AWREADY);
    end
    ar_send(32'h8);
    n_cmp++;
    if (RVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL rvalid_early: got %b, required 0", RVALID); end
    @(negedge clk);
    n_cmp++;
    if (RVALID !== 1'b1 || RDATA !== 32'hA5A5_0001) begin
      n_fail++; $display("[TB] FAIL read_back: RVALID=%b RDATA=%h, required 1/a5a50001", RVALID, RDATA);
    end
    r_take(d);
    n_cmp++;
    if (rd_count !== 16'd1 || ARREADY !== 1'b1) begin
      n_fail++; $display("[TB] FAIL after_r: rd_count=%0d ARREADY=%b, required 1/1", rd_count, ARREADY);
    end
  endtask

  task automatic test_read_latency();
    n_cmp++;
    if (l_ARREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL lat_arready_idle: got %b, required 1", l_ARREADY); end
    l_ARVALID = 1'b1; l_ARADDR = 32'h8;
    @(negedge clk);
    l_ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (l_RVALID !== 1'b0 || l_ARREADY !== 1'b0) begin
        n_fail++; $display("[TB] FAIL lat_wait%0d: RVALID=%b ARREADY=%b, required 0/0", i, l_RVALID, l_ARREADY);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (l_RVALID !== 1'b1 || l_RDATA !== 32'hA5A5_0001) begin
      n_fail++; $display("[TB] FAIL lat_rvalid: RVALID=%b RDATA=%h, required 1/a5a50001", l_RVALID, l_RDATA);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (l_RVALID !== 1'b1 || l_RDATA !== 32'hA5A5_0001 || l_ARREADY !== 1'b0) begin
        n_fail++; $display("[TB] FAIL lat_hold%0d: RVALID=%b RDATA=%h ARREADY=%b, required 1/a5a50001/0", i, l_RVALID, l_RDATA, l_ARREADY);
      end
    end
    l_RREADY = 1'b1;
    @(negedge clk);
    l_RREADY = 1'b0;
    n_cmp++;
    if ({l_RVALID, l_ARREADY} !== 2'b01 || l_rd_count !== 16'd1 || l_wr_count !== 16'd1) begin
      n_fail++; $display("[TB] FAIL lat_done: RVALID,ARREADY=%b rd=%0d wr=%0d, required 01/1/1", {l_RVALID, l_ARREADY}, l_rd_count, l_wr_count);
    end
  endtask

  task automatic test_out_of_range();
    do_write(32'h0, 32'h0000_00C0);
    aw_send(32'h80);
    w_send(32'h1234);
    n_cmp++;
    if (BVALID !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_bvalid: got %b, required 1", BVALID); end
    b_take();
    do_read(32'h0, d);
    n_cmp++;
    if (d !== 32'h0000_00C0) begin n_fail++; $display("[TB] FAIL oor_no_alias: word0=%h, required 000000c0", d); end
    do_read(32'h80, d);
    n_cmp++;
    if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL oor_rdata: got %h, required deadbeef", d); end
    do_write(32'h7C, 32'h7C7C_0001);
    do_read(32'h7C, d);
    n_cmp++;
    if (d !== 32'h7C7C_0001) begin n_fail++; $display("[TB] FAIL last_word: got %h, required 7c7c0001", d); end
  endtask

  task automatic test_collision();
    do_write(32'h8, 32'h11);
    n_cmp++;
    if ({ARREADY, AWREADY} !== 2'b11) begin n_fail++; $display("[TB] FAIL coll_ready: got %b, required 11", {ARREADY, AWREADY}); end
    AWVALID = 1'b1; AWADDR = 32'h8;
    ARVALID = 1'b1; ARADDR = 32'h8;
    @(negedge clk);
    AWVALID = 1'b0; ARVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'h55;
    @(negedge clk);
    WVALID = 1'b0;
    n_cmp++;
    if (RVALID !== 1'b1 || RDATA !== 32'h11 || BVALID !== 1'b1) begin
      n_fail++; $display("[TB] FAIL coll_old: RVALID=%b RDATA=%h BVALID=%b, required 1/00000011/1", RVALID, RDATA, BVALID);
    end
    b_take();
    r_take(d);
    do_read(32'h8, d);
    n_cmp++;
    if (d !== 32'h55) begin n_fail++; $display("[TB] FAIL coll_new: got %h, required 00000055", d); end
  endtask

  task automatic test_reset_mid_write();
    do_write(32'h10, 32'h4444_0004);
    aw_send(32'h10);
    n_cmp++;
    if (WREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_wready: got %b, required 1", WREADY); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({WREADY, BVALID, AWREADY} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL mid_reset: WREADY,BVALID,AWREADY=%b, required 000", {WREADY, BVALID, AWREADY});
    end
    reset = 1'b0;
    WVALID = 1'b1; WDATA = 32'hBAD0_BAD0;
    @(negedge clk);
    n_cmp++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mid_after: AWREADY=%b WREADY=%b, required 1/0", AWREADY, WREADY);
    end
    @(negedge clk);
    n_cmp++;
    if (WREADY !== 1'b0 || BVALID !== 1'b0) begin
      n_fail++; $display("[TB] FAIL early_wvalid: WREADY=%b BVALID=%b, required 0/0", WREADY, BVALID);
    end
    WVALID = 1'b0;
    do_read(32'h10, d);
    n_cmp++;
    if (d !== 32'h4444_0004) begin n_fail++; $display("[TB] FAIL mid_word: got %h, required 44440004", d); end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) do_write(32'(i * 4), 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      do_read(32'(i * 4), held);
      n_cmp++;
      if (held !== 32'(i + 1)) begin n_fail++; $display("[TB] FAIL b2b_word%0d: got %h, required %h", i, held, 32'(i + 1)); end
    end
    n_cmp++;
    if (rd_count !== 16'd4 || wr_count !== 16'd4) begin
      n_fail++; $display("[TB] FAIL b2b_counts: rd=%0d wr=%0d, required 4/4", rd_count, wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_latency();
    test_out_of_range();
    test_collision();
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_responder.md
Name: axi_lite_mem_responder

Overview:
- AXI-lite-style memory responder (slave) for the DMA master's read and write channels.
- Holds a DEPTH x 32-bit word memory. Serves one read and one write transaction at a time, with independent read and write FSMs.
- Sits on the far side of the DMA master as the source and destination memory model. Also usable as a scratch RAM in the SoC.

Parameters:
- DEPTH, 32, number of 32-bit words; power of two, 2..256.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned.
- READ_LAT, 0, extra wait cycles between AR handshake and RVALID; range 0..15.
- ERR_DATA, 32'hDEAD_BEEF, RDATA value returned for out-of-range reads.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARADDR  in  32  read byte address
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RDATA  out  32  read data
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWADDR  in  32  write byte address
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- WDATA  in  32  write data
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- rd_count  out  16  completed read beats (R handshakes), wraps at 2^16
- wr_count  out  16  completed write responses (B handshakes), wraps at 2^16

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - During reset: ARREADY=0, AWREADY=0, RVALID=0, WREADY=0, BVALID=0, RDATA=0, rd_count=0, wr_count=0; both FSMs go to IDLE.
  - Memory array is not reset.
  - First cycle after reset deassertion: ARREADY=1, AWREADY=1.
  - Reset mid-transaction aborts it: any in-flight write whose W handshake has not yet occurred does not modify memory.
- All outputs are registered. A handshake occurs on a rising edge where VALID and READY are both 1.
- Address decode:
  - word index = (ADDR - BASE_ADDR) >> 2, 32-bit unsigned subtract.
  - In range iff ADDR >= BASE_ADDR and index < DEPTH. ADDR[1:0] is ignored (no byte strobes).
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, latch the index and the range flag; ARREADY<=0. Go to R_WAIT if READ_LAT>0, else R_DATA.
  - R_WAIT: count READ_LAT cycles, then go to R_DATA.
  - Entry to R_DATA: RDATA<=mem[index] (ERR_DATA if out of range); RVALID<=1.
  - RVALID rises exactly 1+READ_LAT cycles after the AR handshake edge.
  - R_DATA: hold RVALID and RDATA stable until RREADY=1. On R handshake: RVALID<=0, ARREADY<=1, rd_count+1, go to R_IDLE.
  - ARREADY is 0 in every state except R_IDLE; no read pipelining.
- Write FSM:
  - W_IDLE: AWREADY=1, WREADY=0. On AW handshake, latch the index and the range flag; AWREADY<=0, WREADY<=1, go to W_DATA.
  - W_DATA: on W handshake, mem[index]<=WDATA if in range (discard if out of range); WREADY<=0, BVALID<=1, go to W_RESP.
  - WVALID asserted before the AW handshake is not accepted (WREADY stays 0).
  - W_RESP: hold BVALID until BREADY. On B handshake: BVALID<=0, AWREADY<=1, wr_count+1, go to W_IDLE.
- Read/write interaction:
  - Read and write FSMs run concurrently and independently.
  - Same-edge W handshake and RDATA load to the same word: RDATA gets the old value; the new value is visible to later reads.
- The responder never stalls indefinitely: READY rises at most 1 cycle after the previous transaction completes.

Test Plan:
- Write-then-read, READ_LAT=0, BASE_ADDR=0: AW 0x8, W 0xA5A5_0001, BREADY=1 -> BVALID one cycle after the W handshake, wr_count=1. Then AR 0x8 -> RVALID one cycle after the AR handshake, RDATA=0xA5A5_0001, rd_count=1.
- READ_LAT=3: AR handshake at edge k -> RVALID first high after edge k+4. Hold RREADY=0 for 5 cycles -> RVALID and RDATA stable; ARREADY=0 throughout.
- Out-of-range, DEPTH=32: write 0x1234 to byte address 0x80 -> BVALID still issued, memory unchanged. Read 0x80 -> RDATA=0xDEAD_BEEF.
- Back-to-back DMA pattern: 4 words written to 0x0..0xC from values 1..4, then read back in order -> RDATA 1,2,3,4; rd_count=4, wr_count=4.
- Collision: write 0x55 to word 2 so its W handshake coincides with the RDATA load for word 2, whose old value is 0x11 -> RDATA=0x11; a subsequent read returns 0x55.
- Reset mid-write: AW accepted, reset asserted before WVALID -> WREADY=0, BVALID=0; word unchanged; AWREADY=1 the cycle after reset deasserts.
